// File: rtl/jt6295_pkg.sv
// Shared constants and types for the jt6295 channel scheduler slice.
package jt6295_pkg;
    localparam int NCH    = 4;
    localparam int SW     = 2;
    localparam int AW_DEF = 18;

    typedef enum logic {
        FS_IDLE = 1'b0,
        FS_REQ  = 1'b1
    } fetch_state_t;

    // High nibble plays first; half=1 selects the low nibble.
    function automatic logic [3:0] nibble(input logic [7:0] b, input logic half);
        return half ? b[3:0] : b[7:4];
    endfunction
endpackage

// File: rtl/jt6295_fetch_arb.sv
// Round-robin ROM fetch arbiter: picks a starving channel and runs the IDLE/REQ ROM handshake.
module jt6295_fetch_arb
    import jt6295_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NCH-1:0]         need,
    input  logic [NCH-1:0][AW-1:0] ptr,
    input  logic [SW-1:0]          slot_ctr,
    input  logic [7:0]             rom_data,
    input  logic                   rom_ok,
    output logic                   rom_cs,
    output logic [AW-1:0]          rom_addr,
    output logic                   gnt,
    output logic [SW-1:0]          gnt_ch,
    output logic [7:0]             gnt_data,
    output fetch_state_t           state
);
    logic          found;
    logic [SW-1:0] sel;
    logic [SW-1:0] idx;

    // Scan starts at the slot about to be played so the most urgent channel wins.
    always_comb begin
        found = 1'b0;
        sel   = slot_ctr;
        idx   = slot_ctr;
        for (int i = 0; i < NCH; i++) begin
            idx = slot_ctr + SW'(i);
            if (!found && need[idx]) begin
                found = 1'b1;
                sel   = idx;
            end
        end
    end

    // ROM handshake: rom_cs is the request valid and rom_ok the ready; rom_addr is
    // held while rom_cs=1 and the byte transfers on the edge where both are high.
    assign gnt      = (state == FS_REQ) && rom_ok;
    assign gnt_data = rom_data;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= FS_IDLE;
            rom_cs   <= 1'b0;
            rom_addr <= '0;
            gnt_ch   <= '0;
        end else begin
            case (state)
                FS_IDLE: if (found) begin
                    gnt_ch   <= sel;
                    rom_addr <= ptr[sel];
                    rom_cs   <= 1'b1;
                    state    <= FS_REQ;
                end
                FS_REQ: if (rom_ok) begin
                    rom_cs <= 1'b0;
                    state  <= FS_IDLE;
                end
                default: state <= FS_IDLE;
            endcase
        end
    end
endmodule

// File: rtl/jt6295_ch_sched.sv
// Four-channel voice scheduler: per-channel ROM pointers and nibble feed into the ADPCM pipe.
module jt6295_ch_sched
    import jt6295_pkg::*;
#(
    parameter int AW = AW_DEF
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cen,
    input  logic          start,
    input  logic [1:0]    start_ch,
    input  logic [AW-1:0] start_addr,
    input  logic [AW-1:0] stop_addr,
    input  logic [3:0]    start_att,
    input  logic [3:0]    stop,
    output logic [3:0]    busy,
    output logic          underrun,
    output logic          rom_cs,
    output logic [AW-1:0] rom_addr,
    input  logic [7:0]    rom_data,
    input  logic          rom_ok,
    output logic          en,
    output logic [3:0]    att,
    output logic [3:0]    data,
    output logic [1:0]    slot
);
    logic [NCH-1:0]          active, half, bvalid;
    logic [NCH-1:0][AW-1:0]  ptr, stp;
    logic [NCH-1:0][3:0]     att_r;
    logic [NCH-1:0][7:0]     bdata;
    logic [SW-1:0]           slot_ctr;
    logic [NCH-1:0]          kill, live, need;
    logic                    start_acc, gnt, drop, wr;
    logic [SW-1:0]           gnt_ch;
    logic [7:0]              gnt_data;
    fetch_state_t            fetch_state;

    // A stop in the same cycle beats a start on that channel.
    assign start_acc = start && !active[start_ch] && !stop[start_ch];
    assign kill      = stop | (start_acc ? (4'b0001 << start_ch) : 4'b0000);
    assign live      = active & ~stop;
    assign need      = live & ~bvalid;
    assign busy      = active;
    assign wr        = gnt && !drop && !kill[gnt_ch];

    jt6295_fetch_arb #(.AW(AW)) u_arb (
        .clk      (clk),
        .rst      (rst),
        .need     (need),
        .ptr      (ptr),
        .slot_ctr (slot_ctr),
        .rom_data (rom_data),
        .rom_ok   (rom_ok),
        .rom_cs   (rom_cs),
        .rom_addr (rom_addr),
        .gnt      (gnt),
        .gnt_ch   (gnt_ch),
        .gnt_data (gnt_data),
        .state    (fetch_state)
    );

    // A byte in flight for a channel that was stopped or re-armed is stale.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                       drop <= 1'b0;
        else if (fetch_state != FS_REQ) drop <= 1'b0;
        else if (kill[gnt_ch])          drop <= 1'b1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            active   <= '0;
            half     <= '0;
            bvalid   <= '0;
            ptr      <= '0;
            stp      <= '0;
            att_r    <= '0;
            bdata    <= '0;
            slot_ctr <= '0;
            underrun <= 1'b0;
            en       <= 1'b0;
            att      <= '0;
            data     <= '0;
            slot     <= '0;
        end else begin
            if (cen) begin
                slot     <= slot_ctr;
                en       <= live[slot_ctr];
                att      <= att_r[slot_ctr];
                data     <= 4'd0;
                slot_ctr <= slot_ctr + 2'd1;
                if (live[slot_ctr]) begin
                    if (bvalid[slot_ctr]) begin
                        data           <= nibble(bdata[slot_ctr], half[slot_ctr]);
                        half[slot_ctr] <= ~half[slot_ctr];
                        if (half[slot_ctr]) begin
                            bvalid[slot_ctr] <= 1'b0;
                            if (ptr[slot_ctr] == stp[slot_ctr]) active[slot_ctr] <= 1'b0;
                            else ptr[slot_ctr] <= ptr[slot_ctr] + AW'(1);
                        end
                    end else begin
                        underrun <= 1'b1;
                    end
                end
            end
            if (wr) begin
                bdata[gnt_ch]  <= gnt_data;
                bvalid[gnt_ch] <= 1'b1;
            end
            if (start_acc) begin
                ptr[start_ch]    <= start_addr;
                stp[start_ch]    <= stop_addr;
                att_r[start_ch]  <= start_att;
                half[start_ch]   <= 1'b0;
                bvalid[start_ch] <= 1'b0;
                active[start_ch] <= 1'b1;
            end
            for (int n = 0; n < NCH; n++) begin
                if (stop[n]) begin
                    active[n] <= 1'b0;
                    bvalid[n] <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_jt6295_ch_sched.sv
// Directed bench for jt6295_ch_sched with a ROM model and nibble/fetch scoreboards.
module tb_jt6295_ch_sched;
    localparam int AW = 18;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cen = 1'b0;
    logic          start = 1'b0;
    logic [1:0]    start_ch = '0;
    logic [AW-1:0] start_addr = '0;
    logic [AW-1:0] stop_addr = '0;
    logic [3:0]    start_att = '0;
    logic [3:0]    stop = '0;
    logic [3:0]    busy;
    logic          underrun;
    logic          rom_cs;
    logic [AW-1:0] rom_addr;
    logic [7:0]    rom_data;
    logic          rom_ok;
    logic          en;
    logic [3:0]    att;
    logic [3:0]    data;
    logic [1:0]    slot;

    int            n_cmp = 0;
    int            n_mis = 0;
    logic [9:0]    exp_q[$];
    logic [AW-1:0] exp_addr_q[$];
    logic [1:0]    exp_slot = '0;
    logic          rom_hold = 1'b0;
    int            rom_delay = 0;
    int            wait_cnt = 0;

    jt6295_ch_sched #(.AW(AW)) dut (
        .clk        (clk),
        .rst        (rst),
        .cen        (cen),
        .start      (start),
        .start_ch   (start_ch),
        .start_addr (start_addr),
        .stop_addr  (stop_addr),
        .start_att  (start_att),
        .stop       (stop),
        .busy       (busy),
        .underrun   (underrun),
        .rom_cs     (rom_cs),
        .rom_addr   (rom_addr),
        .rom_data   (rom_data),
        .rom_ok     (rom_ok),
        .en         (en),
        .att        (att),
        .data       (data),
        .slot       (slot)
    );

    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    function automatic logic [7:0] rom_byte(input logic [AW-1:0] a);
        if (a == 18'h100) return 8'h12;
        if (a == 18'h101) return 8'h34;
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // ROM model: answers after rom_delay wait cycles unless held off.
    always @(posedge clk) begin
        if (!rom_cs || rom_ok) wait_cnt <= 0;
        else                   wait_cnt <= wait_cnt + 1;
    end
    assign rom_ok   = rom_cs && !rom_hold && (wait_cnt >= rom_delay);
    assign rom_data = rom_byte(rom_addr);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Fetch scoreboard: every accepted ROM transfer must match the next expected address.
    always @(negedge clk) begin
        if (!rst && rom_cs && rom_ok) begin
            if (exp_addr_q.size() == 0) chk("fetch_extra", {31'd0, rom_cs}, 32'd0);
            else chk("fetch_addr", {14'd0, rom_addr}, {14'd0, exp_addr_q.pop_front()});
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic start_pulse(input logic [1:0] ch, input logic [AW-1:0] sa,
                               input logic [AW-1:0] ea, input logic [3:0] a,
                               input logic [3:0] smask);
        start = 1'b1; start_ch = ch; start_addr = sa; stop_addr = ea;
        start_att = a; stop = smask;
        @(negedge clk);
        start = 1'b0; stop = 4'd0;
    endtask

    task automatic stop_pulse(input logic [3:0] mask);
        stop = mask;
        @(negedge clk);
        stop = 4'd0;
    endtask

    task automatic expect_play(input logic [1:0] ch, input logic [AW-1:0] sa,
                               input logic [AW-1:0] ea, input logic [3:0] a);
        logic [AW-1:0] p;
        logic [7:0]    b;
        p = sa;
        for (int k = 0; k < 64; k++) begin
            b = rom_byte(p);
            exp_q.push_back({ch, a, b[7:4]});
            exp_q.push_back({ch, a, b[3:0]});
            exp_addr_q.push_back(p);
            if (p == ea) break;
            p = p + 1'b1;
        end
    endtask

    // One cen pulse, check the registered slot output, then leave room for fetches.
    task automatic slot_step();
        int idx;
        cen = 1'b1;
        @(negedge clk);
        cen = 1'b0;
        chk("slot", {30'd0, slot}, {30'd0, exp_slot});
        idx = -1;
        for (int i = 0; i < exp_q.size(); i++) begin
            if (idx < 0 && exp_q[i][9:8] == exp_slot) idx = i;
        end
        chk("en", {31'd0, en}, {31'd0, idx >= 0});
        if (en && idx >= 0) begin
            chk("nibble", {22'd0, slot, att, data}, {22'd0, exp_q[idx]});
            exp_q.delete(idx);
        end else if (!en) begin
            chk("idle_data", {28'd0, data}, 32'd0);
        end
        exp_slot = exp_slot + 2'd1;
        tick(3);
    endtask

    task automatic run_slots(input int n);
        for (int i = 0; i < n; i++) slot_step();
    endtask

    initial begin
        tick(2);
        chk("rst_busy", {28'd0, busy}, 32'd0);
        chk("rst_en", {31'd0, en}, 32'd0);
        chk("rst_data", {28'd0, data}, 32'd0);
        chk("rst_att", {28'd0, att}, 32'd0);
        chk("rst_slot", {30'd0, slot}, 32'd0);
        chk("rst_cs", {31'd0, rom_cs}, 32'd0);
        chk("rst_addr", {14'd0, rom_addr}, 32'd0);
        chk("rst_underrun", {31'd0, underrun}, 32'd0);
        rst = 1'b0;

        // Two-byte play on ch0 with an always-ready ROM.
        expect_play(2'd0, 18'h100, 18'h101, 4'd5);
        start_pulse(2'd0, 18'h100, 18'h101, 4'd5, 4'd0);
        tick(3);
        chk("t1_busy", {28'd0, busy}, 32'd1);
        run_slots(17);
        chk("t1_busy_end", {28'd0, busy}, 32'd0);

        // Back-to-back starts on ch1/ch2 with a slow ROM.
        rom_delay = 3;
        expect_play(2'd1, 18'h200, 18'h200, 4'd7);
        start_pulse(2'd1, 18'h200, 18'h200, 4'd7, 4'd0);
        expect_play(2'd2, 18'h300, 18'h300, 4'd9);
        start_pulse(2'd2, 18'h300, 18'h300, 4'd9, 4'd0);
        tick(14);
        run_slots(8);
        chk("t2_underrun", {31'd0, underrun}, 32'd0);
        chk("t2_busy", {28'd0, busy}, 32'd0);

        // ROM stalled across a ch3 slot: zero nibble, sticky underrun, byte replayed later.
        rom_delay = 0;
        rom_hold  = 1'b1;
        exp_q.push_back({2'd3, 4'd3, 4'd0});
        expect_play(2'd3, 18'h400, 18'h400, 4'd3);
        start_pulse(2'd3, 18'h400, 18'h400, 4'd3, 4'd0);
        tick(2);
        chk("t3_cs", {31'd0, rom_cs}, 32'd1);
        chk("t3_addr", {14'd0, rom_addr}, 32'h400);
        run_slots(4);
        chk("t3_underrun", {31'd0, underrun}, 32'd1);
        chk("t3_cs_held", {31'd0, rom_cs}, 32'd1);
        chk("t3_addr_held", {14'd0, rom_addr}, 32'h400);
        rom_hold = 1'b0;
        tick(2);
        run_slots(8);
        chk("t3_busy", {28'd0, busy}, 32'd0);

        // Start+stop together on idle ch0, then a start on busy ch0 that must be ignored.
        start_pulse(2'd0, 18'h500, 18'h501, 4'hA, 4'b0001);
        tick(2);
        chk("t4_busy_ign", {28'd0, busy}, 32'd0);
        chk("t4_cs", {31'd0, rom_cs}, 32'd0);
        expect_play(2'd0, 18'h500, 18'h501, 4'hA);
        start_pulse(2'd0, 18'h500, 18'h501, 4'hA, 4'd0);
        start_pulse(2'd0, 18'h600, 18'h600, 4'hF, 4'd0);
        tick(3);
        chk("t4_busy", {28'd0, busy}, 32'd1);
        run_slots(16);
        chk("t4_busy_end", {28'd0, busy}, 32'd0);

        // Stop ch2 while its fetch is outstanding.
        rom_hold = 1'b1;
        exp_addr_q.push_back(18'h700);
        start_pulse(2'd2, 18'h700, 18'h701, 4'd6, 4'd0);
        tick(2);
        chk("t5_cs", {31'd0, rom_cs}, 32'd1);
        chk("t5_addr", {14'd0, rom_addr}, 32'h700);
        stop_pulse(4'b0100);
        chk("t5_busy", {28'd0, busy}, 32'd0);
        chk("t5_cs_held", {31'd0, rom_cs}, 32'd1);
        rom_hold = 1'b0;
        tick(2);
        chk("t5_cs_drop", {31'd0, rom_cs}, 32'd0);
        run_slots(4);

        // Top-of-ROM single byte: no wrap fetch afterwards.
        expect_play(2'd1, 18'h3FFFF, 18'h3FFFF, 4'd2);
        start_pulse(2'd1, 18'h3FFFF, 18'h3FFFF, 4'd2, 4'd0);
        tick(3);
        run_slots(8);
        chk("t6_busy", {28'd0, busy}, 32'd0);
        chk("t6_exp_left", exp_q.size(), 32'd0);
        chk("t6_addr_left", exp_addr_q.size(), 32'd0);

        // Reset during an outstanding request.
        rom_hold = 1'b1;
        exp_addr_q.push_back(18'h800);
        start_pulse(2'd3, 18'h800, 18'h800, 4'd1, 4'd0);
        tick(2);
        chk("t6_cs", {31'd0, rom_cs}, 32'd1);
        rst = 1'b1;
        #1;
        chk("t6_rst_cs", {31'd0, rom_cs}, 32'd0);
        chk("t6_rst_addr", {14'd0, rom_addr}, 32'd0);
        chk("t6_rst_busy", {28'd0, busy}, 32'd0);
        chk("t6_rst_underrun", {31'd0, underrun}, 32'd0);
        chk("t6_rst_slot", {30'd0, slot}, 32'd0);
        exp_q.delete();
        exp_addr_q.delete();
        exp_slot = '0;
        rom_hold = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(4);
        chk("t6_post_cs", {31'd0, rom_cs}, 32'd0);
        chk("t6_post_busy", {28'd0, busy}, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end
endmodule
